bus_response_mux: RTL
=====================

// Module: bus_response_mux
// PURPOSE
//   Return-path partner of the peripheral address decoder: the decoder fans a request out to one
//   slave (IMEM, DMEM, UART, GPIO, TIMER), and this block collects the response.
//   Sits between the core's load/store port and the slave response signals.
//   Latches the one-hot slave select, holds the request strobe to that slave, and waits for its
//   ready. Returns the read data, or an error on an unmapped address or a slave timeout.
// PARAMETERS
//   NUM_SLAVES      5             number of slave ports; bit i of every vector = slave i
//                                 order: 0=imem 1=dmem 2=uart 3=gpio 4=timer
//   DATA_W          32            read data width
//   TIMEOUT_CYCLES  16            max WAIT cycles before error response; legal range >= 1
//   ERR_RDATA       32'hDEAD_BEEF rsp_rdata value driven with rsp_err
// PORTS
//   clk        in   1                  system clock, all logic on rising edge
//   rst        in   1                  synchronous, active-high reset
//   req_valid  in   1                  core request strobe, sampled only when req_ready=1
//   req_sel    in   NUM_SLAVES         one-hot select from address decoder, sampled with req_valid
//   req_ready  out  1                  1 in IDLE only
//   s_req      out  NUM_SLAVES         latched select, driven only in WAIT state, else 0
//   s_ready    in   NUM_SLAVES         per-slave response ready
//   s_rdata    in   NUM_SLAVES*DATA_W  per-slave read data; slice i = [i*DATA_W +: DATA_W]
//   rsp_valid  out  1                  one-cycle response pulse
//   rsp_rdata  out  DATA_W             response data, held until next response
//   rsp_err    out  1                  qualifies rsp_valid: 1 = unmapped or timed out
//   busy       out  1                  1 in WAIT or RESP
// BEHAVIOUR
//   States:
//   - FSM states: IDLE, WAIT, RESP. Registered state, sel_q, timeout counter, rsp_rdata, rsp_err.
//   Reset:
//   - rst=1 -> IDLE; sel_q=0, count=0, rsp_rdata=0, rsp_err=0.
//   - Outputs after reset: req_ready=1, s_req=0, rsp_valid=0, busy=0.
//   - Reset mid-transaction abandons it: no rsp_valid is ever produced for it.
//   IDLE:
//   - req_valid=1 and req_sel exactly one-hot -> sel_q<=req_sel, count<=0, go WAIT.
//   - req_valid=1 and req_sel zero or multi-hot -> rsp_err<=1, rsp_rdata<=ERR_RDATA, go RESP.
//     No slave is strobed.
//   WAIT:
//   - s_req=sel_q. s_ready bits of non-selected slaves are ignored.
//   - s_ready&sel_q nonzero -> rsp_rdata<=selected slice, rsp_err<=0, go RESP.
//   - Otherwise, if count==TIMEOUT_CYCLES-1 -> rsp_err<=1, rsp_rdata<=ERR_RDATA, go RESP.
//   - Otherwise count<=count+1.
//   - Ready on the terminal-count cycle wins over timeout (no error).
//   RESP:
//   - rsp_valid=1 for exactly one cycle, then IDLE.
//   - req_valid is ignored while not IDLE; the core must hold or re-issue it.
//   Latency (request accepted at cycle 0):
//   - Mapped slave, s_ready in cycle 1 -> rsp_valid in cycle 2 (minimum).
//   - Slave ready k cycles after WAIT entry (k < TIMEOUT_CYCLES) -> rsp_valid at cycle 2+k.
//   - Unmapped -> rsp_valid in cycle 1.
//   - Timeout -> rsp_valid in cycle TIMEOUT_CYCLES+1.
//   Widths:
//   - count width = $clog2(TIMEOUT_CYCLES+1); no wrap is possible since terminal count exits WAIT.
//   - Back-to-back: the next request can be accepted in the cycle after RESP (IDLE).
// TESTING
//   1 Reset: assert rst 2 cycles mid-WAIT -> next cycle req_ready=1, s_req=0, rsp_valid=0,
//     rsp_rdata=0; no response pulse follows.
//   2 GPIO read: req_sel=5'b01000 at c0, s_ready[3]=1 with s_rdata slice 0x0000_00A5 in c1 ->
//     rsp_valid=1, rsp_err=0, rsp_rdata=0xA5 in c2.
//   3 Unmapped: req_sel=0 -> rsp_valid=1, rsp_err=1, rsp_rdata=0xDEADBEEF in c1; s_req stays 0.
//   4 Timeout: UART selected, s_ready=0 forever -> s_req=5'b00100 for 16 cycles;
//     rsp_err=1 at c17.
//   5 Race: ready on the 16th WAIT cycle -> rsp_err=0 with slave data.
//     Ready only on a non-selected slave -> ignored, timeout still fires.
//   6 Multi-hot req_sel=5'b00011 -> error in c1. Then back-to-back DMEM, then TIMER requests ->
//     each returns its own slice, busy low exactly one cycle between them.

Source files
------------

// File: rtl/bus_response_mux.sv
// Response collector for the peripheral bus.
// A request from the core's load/store port is routed to one slave by the
// address decoder. This block latches that one-hot select and holds the
// strobe to that slave until it signals ready. It then returns the slave's
// read data to the core as a single-cycle response.
//
// An error response is returned in two cases:
//   - the select is zero or multi-hot (an unmapped address), or
//   - the slave stays silent for TIMEOUT_CYCLES cycles.
//
// Handshake contract (valid/ready):
//   - The core's req_valid/req_sel pair is consumed only on a rising edge
//     where req_ready=1, which is true only in IDLE.
//   - req_valid is ignored in every other cycle, so the core must hold it
//     or re-issue it.
//   - s_req is a level strobe, held to the selected slave for the whole
//     WAIT state.
//   - That slave completes the transfer by raising its s_ready bit on any
//     WAIT cycle. Its s_rdata slice is captured on the same edge.
//   - rsp_valid is a one-cycle pulse with no back-pressure. rsp_err
//     qualifies it.
//   - rsp_rdata stays stable until the next response.
// All outputs are registered. fsm_state exposes the FSM for checkers.
module bus_response_mux #(
    parameter int                NUM_SLAVES     = 5,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic [NUM_SLAVES-1:0]        req_sel,
    output logic                         req_ready,
    output logic [NUM_SLAVES-1:0]        s_req,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         busy,
    output logic [1:0]                   fsm_state
);

    // Counter only has to reach TIMEOUT_CYCLES-1; the terminal count
    // leaves WAIT, so the counter can never wrap.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [NUM_SLAVES-1:0]   sel_q;
    logic [CNT_W-1:0]        count;
    logic                    ready_hit;
    logic [DATA_W-1:0]       rdata_sel;

    // True when exactly one bit of the select vector is set.
    function automatic logic is_onehot(input logic [NUM_SLAVES-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (v[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
        return seen && !multi;
    endfunction

    // Only the latched slave's ready matters; stray ready bits from other
    // slaves are masked off here.
    always_comb begin
        ready_hit = |(s_ready & sel_q);
    end

    // Read-data mux: sel_q is one-hot in WAIT, so an AND-OR selects exactly
    // one slice without a priority chain.
    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                rdata_sel = rdata_sel | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign fsm_state = state;

    // Transaction FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel_q     <= '0;
            count     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            s_req     <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (is_onehot(req_sel)) begin
                            sel_q <= req_sel;
                            count <= '0;
                            s_req <= req_sel;
                            state <= ST_WAIT;
                        end else begin
                            // Unmapped address: answer immediately, no strobe.
                            rsp_err   <= 1'b1;
                            rsp_rdata <= ERR_RDATA;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end

                ST_WAIT: begin
                    if (ready_hit) begin
                        // Ready wins even on the terminal-count cycle.
                        rsp_rdata <= rdata_sel;
                        rsp_err   <= 1'b0;
                        s_req     <= '0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (count == LAST_COUNT) begin
                        rsp_rdata <= ERR_RDATA;
                        rsp_err   <= 1'b1;
                        s_req     <= '0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    rsp_valid <= 1'b0;
                    s_req     <= '0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
